// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter: time-shares one port between instruction fetch
// and load/store, serialising 1/2/4-byte accesses into single-byte transfers.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t            state, state_d;
    logic [2:0]        idx, idx_d;
    logic [2:0]        n, n_d;
    logic [ADDR_W-1:0] base, base_d;
    logic [31:0]       shreg, shreg_d;
    logic              owner, owner_d;
    logic              last_grant, last_grant_d;
    logic [ADDR_W-1:0] mem_a_d;
    logic [7:0]        mem_dout_d;
    logic              wr_q, wr_d;
    logic              if_done_d, ls_done_d;
    logic [31:0]       if_data_d, ls_rdata_d;

    logic              if_elig, ls_elig, grant_any, grant_ls;
    logic [2:0]        grant_n, next_idx;
    logic              io_stall, ls_io_stall;
    logic [ADDR_W-1:0] cur_addr, next_addr;
    logic [1:0]        cap_sel;

    assign mem_wr = wr_q & rdy;

    // A port whose done is high this cycle is still holding req from the finished access.
    assign if_elig   = if_req && !if_done;
    assign ls_elig   = ls_req && !ls_done && !(clr && !ls_wr);
    assign grant_any = if_elig || ls_elig;
    assign grant_ls  = ls_elig && (!if_elig || last_grant == OWN_IF);

    always_comb begin
        case (ls_size)
            2'b00:   grant_n = 3'd1;
            2'b01:   grant_n = 3'd2;
            default: grant_n = 3'd4;
        endcase
    end

    assign io_stall    = (base[17:16] == IO_HI) && io_buffer_full;
    assign ls_io_stall = (ls_addr[17:16] == IO_HI) && io_buffer_full;
    assign next_idx    = idx + 3'd1;
    assign cur_addr    = base + ADDR_W'(idx);
    assign next_addr   = base + ADDR_W'(next_idx);
    assign cap_sel     = idx[1:0] - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            n          <= '0;
            base       <= '0;
            shreg      <= '0;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            mem_a      <= '0;
            mem_dout   <= '0;
            wr_q       <= 1'b0;
            if_done    <= 1'b0;
            ls_done    <= 1'b0;
            if_data    <= '0;
            ls_rdata   <= '0;
        end else if (rdy) begin
            state      <= state_d;
            idx        <= idx_d;
            n          <= n_d;
            base       <= base_d;
            shreg      <= shreg_d;
            owner      <= owner_d;
            last_grant <= last_grant_d;
            mem_a      <= mem_a_d;
            mem_dout   <= mem_dout_d;
            wr_q       <= wr_d;
            if_done    <= if_done_d;
            ls_done    <= ls_done_d;
            if_data    <= if_data_d;
            ls_rdata   <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (grant_any) state_d = (grant_ls && ls_wr) ? WRITE : READ;
            READ:    if (clr || idx == n) state_d = IDLE;
            WRITE:   if (wr_q && idx == n - 3'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d        = idx;
        n_d          = n;
        base_d       = base;
        shreg_d      = shreg;
        owner_d      = owner;
        last_grant_d = last_grant;
        mem_a_d      = mem_a;
        mem_dout_d   = mem_dout;
        wr_d         = 1'b0;
        if_done_d    = 1'b0;
        ls_done_d    = 1'b0;
        if_data_d    = if_data;
        ls_rdata_d   = ls_rdata;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    owner_d      = grant_ls;
                    last_grant_d = grant_ls;
                    idx_d        = '0;
                    shreg_d      = '0;
                    if (grant_ls) begin
                        base_d  = ls_addr;
                        n_d     = grant_n;
                        mem_a_d = ls_addr;
                        if (ls_wr) begin
                            shreg_d = ls_wdata;
                            if (!ls_io_stall) begin
                                mem_dout_d = ls_wdata[7:0];
                                wr_d       = 1'b1;
                            end
                        end
                    end else begin
                        base_d  = if_addr;
                        n_d     = 3'd4;
                        mem_a_d = if_addr;
                    end
                end
            end
            READ: begin
                // idx counts edges since grant; byte idx-1 arrives on mem_din now.
                if (!clr) begin
                    if (idx != 3'd0) shreg_d[{cap_sel, 3'b000} +: 8] = mem_din;
                    if (idx == n) begin
                        if (owner == OWN_LS) begin
                            ls_rdata_d = shreg_d;
                            ls_done_d  = 1'b1;
                        end else begin
                            if_data_d = shreg_d;
                            if_done_d = 1'b1;
                        end
                    end else if (next_idx < n) begin
                        mem_a_d = next_addr;
                    end
                    idx_d = next_idx;
                end
            end
            WRITE: begin
                // wr_q high means byte idx has been on the bus for a full cycle.
                if (wr_q) begin
                    if (idx == n - 3'd1) begin
                        ls_done_d = 1'b1;
                    end else begin
                        idx_d   = next_idx;
                        mem_a_d = next_addr;
                        if (!io_stall) begin
                            mem_dout_d = shreg[{next_idx[1:0], 3'b000} +: 8];
                            wr_d       = 1'b1;
                        end
                    end
                end else if (!io_stall) begin
                    mem_a_d    = cur_addr;
                    mem_dout_d = shreg[{idx[1:0], 3'b000} +: 8];
                    wr_d       = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of load/store transactions against a
// byte RAM model, plus hand sequences for arbitration, flush, IO stall, rdy and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_wr, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM model: preload in rom, writes land in ram; read data one cycle after address.
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wlog_t;
    logic [7:0] rom [logic [31:0]];
    logic [7:0] ram [logic [31:0]];
    wlog_t      wlog [$];
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : (rom.exists(mem_a) ? rom[mem_a] : 8'h00);
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wlog.push_back('{mem_a, mem_dout, cyc});
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        io;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
    } vec_t;
    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_done(input bit on_ls, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!(on_ls ? ls_done : if_done) && edges < 20);
        if (!(on_ls ? ls_done : if_done)) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done after %0d edges required=done", edges);
        end
    endtask

    task automatic ls_start(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        ls_wr    = wr;
        ls_size  = size;
        ls_addr  = addr;
        ls_wdata = wdata;
        ls_req   = 1'b1;
    endtask

    initial begin
        int e, base_n, ncomp;
        int order [6];
        int tdone [6];

        for (int k = 0; k < 4; k++) begin
            rom[32'h201 + k] = 8'h00;
            rom[32'h400 + k] = 8'h11 * (k + 1);
            rom[32'h500 + k] = 8'hA1 + k;
            rom[32'h600 + k] = 8'h61 + k;
        end
        rom[32'h201] = 8'h80;
        rom[32'h202] = 8'hFF;
        rom[32'h302] = 8'h56;
        rom[32'h303] = 8'h78;

        rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
        tick(); tick();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_dones", {30'b0, if_done, ls_done}, 32'h0);
        chk("rst_data", if_data | ls_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Simultaneous requests after reset: LS first, then strict alternation.
        if_addr = 32'h400; if_req = 1'b1;
        ls_start(1'b0, 2'b10, 32'h500, 32'h0);
        tick();
        chk("tie_first_grant_addr", mem_a, 32'h500);
        ncomp = 0;
        for (int t = 1; t <= 40 && ncomp < 4; t++) begin
            tick();
            if (t == 6) chk("tie_if_grant_addr", mem_a, 32'h400);
            if (ls_done && ncomp < 6) begin
                order[ncomp] = 1; tdone[ncomp] = t; ncomp++;
                chk("tie_ls_rdata", ls_rdata, 32'hA4A3A2A1);
            end
            if (if_done && ncomp < 6) begin
                order[ncomp] = 0; tdone[ncomp] = t; ncomp++;
                chk("tie_if_data", if_data, 32'h44332211);
            end
            if (ncomp >= 4) begin if_req = 1'b0; ls_req = 1'b0; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("tie_completions", ncomp, 4);
        chk("tie_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]}, 32'h1010);
        chk("tie_ls_done_cycle", tdone[0], 5);
        chk("tie_if_done_cycle", tdone[1], 11);
        tick();

        // Flush a word fetch after byte 1 is captured; the refetch gets a fresh address.
        if_addr = 32'h400; if_req = 1'b1;
        tick(); tick(); tick(); tick();
        clr = 1'b1; if_addr = 32'h600;
        tick();
        chk("clr_no_done", {31'b0, if_done}, 32'h0);
        chk("clr_if_data_kept", if_data, 32'h44332211);
        clr = 1'b0;
        tick();
        chk("clr_regrant_addr", mem_a, 32'h600);
        wait_done(1'b0, e);
        if_req = 1'b0;
        chk("clr_refetch_lat", e, 5);
        chk("clr_refetch_data", if_data, 32'h64636261);
        tick();

        // Word store: four consecutive byte writes, little-endian.
        base_n = wlog.size();
        ls_start(1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
        tick();
        wait_done(1'b1, e);
        ls_req = 1'b0;
        chk("st_word_lat", e, 4);
        chk("st_word_nwr", wlog.size() - base_n, 4);
        if (wlog.size() - base_n == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("st_word_addr", wlog[base_n + k].a, 32'h100 + k);
                chk("st_word_byte", {24'b0, wlog[base_n + k].d}, (32'hDEADBEEF >> (8 * k)) & 32'hFF);
                chk("st_word_consecutive", wlog[base_n + k].cyc, wlog[base_n].cyc + k);
            end
        end
        tick();

        // Half load at odd address: check address sequence.
        ls_start(1'b0, 2'b01, 32'h201, 32'h0);
        tick();
        chk("half_addr0", mem_a, 32'h201);
        tick();
        chk("half_addr1", mem_a, 32'h202);
        wait_done(1'b1, e);
        ls_req = 1'b0;
        chk("half_lat_rest", e, 2);
        chk("half_rdata", ls_rdata, 32'h0000FF80);
        tick();

        tbl[0] = '{1'b0, 2'b10, 32'h00000100, 32'h0,        1'b0, 32'hDEADBEEF, 5, 0};
        tbl[1] = '{1'b0, 2'b00, 32'h00000103, 32'h0,        1'b0, 32'h000000DE, 2, 0};
        tbl[2] = '{1'b0, 2'b11, 32'h00000100, 32'h0,        1'b0, 32'hDEADBEEF, 5, 0};
        tbl[3] = '{1'b1, 2'b01, 32'h00000300, 32'hAAAA1234, 1'b0, 32'h0,        2, 2};
        tbl[4] = '{1'b0, 2'b10, 32'h00000300, 32'h0,        1'b0, 32'h78561234, 5, 0};
        tbl[5] = '{1'b1, 2'b01, 32'hFFFFFFFF, 32'h0000C3A5, 1'b0, 32'h0,        2, 2};
        tbl[6] = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h0000C3A5, 3, 0};
        tbl[7] = '{1'b1, 2'b00, 32'h00020000, 32'h0000005A, 1'b1, 32'h0,        1, 1};
        tbl[8] = '{1'b0, 2'b00, 32'h00020000, 32'h0,        1'b1, 32'h0000005A, 2, 0};
        tbl[9] = '{1'b0, 2'b01, 32'h00000201, 32'h0,        1'b0, 32'h0000FF80, 3, 0};

        for (int i = 0; i < 10; i++) begin
            base_n = wlog.size();
            io_buffer_full = tbl[i].io;
            ls_start(tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata);
            tick();
            wait_done(1'b1, e);
            ls_req = 1'b0;
            chk($sformatf("vec%0d_lat", i), e, tbl[i].lat);
            chk($sformatf("vec%0d_nwr", i), wlog.size() - base_n, tbl[i].nwr);
            if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), ls_rdata, tbl[i].rdata);
            tick();
            chk($sformatf("vec%0d_done_width", i), {31'b0, ls_done}, 32'h0);
            io_buffer_full = 1'b0;
        end

        // IO byte store stalled three edges by a full write buffer; clr must not cancel it.
        base_n = wlog.size();
        io_buffer_full = 1'b1;
        ls_start(1'b1, 2'b00, 32'h00030000, 32'h00000077);
        tick();
        chk("io_stall_e0", {31'b0, mem_wr}, 32'h0);
        clr = 1'b1;
        tick();
        chk("io_stall_e1", {31'b0, mem_wr}, 32'h0);
        clr = 1'b0;
        tick();
        chk("io_stall_e2", {31'b0, mem_wr}, 32'h0);
        io_buffer_full = 1'b0;
        tick();
        chk("io_write_strobe", {31'b0, mem_wr}, 32'h1);
        chk("io_write_addr", mem_a, 32'h00030000);
        chk("io_write_byte", {24'b0, mem_dout}, 32'h77);
        tick();
        chk("io_done", {31'b0, ls_done}, 32'h1);
        chk("io_wr_released", {31'b0, mem_wr}, 32'h0);
        ls_req = 1'b0;
        chk("io_single_write", wlog.size() - base_n, 1);
        chk("io_ram_byte", {24'b0, ram.exists(32'h30000) ? ram[32'h30000] : 8'h00}, 32'h77);
        tick();

        // rdy low freezes a byte store and gates mem_wr.
        base_n = wlog.size();
        ls_start(1'b1, 2'b00, 32'h700, 32'h0000003C);
        tick();
        chk("rdy_wr_before", {31'b0, mem_wr}, 32'h1);
        rdy = 1'b0;
        #1;
        chk("rdy_wr_gated", {31'b0, mem_wr}, 32'h0);
        tick(); tick();
        chk("rdy_frozen_no_done", {31'b0, ls_done}, 32'h0);
        rdy = 1'b1;
        #1;
        chk("rdy_wr_resumed", {31'b0, mem_wr}, 32'h1);
        tick();
        chk("rdy_done", {31'b0, ls_done}, 32'h1);
        ls_req = 1'b0;
        chk("rdy_single_write", wlog.size() - base_n, 1);
        tick();

        // Asynchronous reset mid word fetch, then the first tie goes to LS again.
        if_addr = 32'h400; if_req = 1'b1;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_a", mem_a, 32'h0);
        chk("arst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("arst_data", if_data | ls_rdata, 32'h0);
        chk("arst_ctrl", {29'b0, mem_wr, if_done, ls_done}, 32'h0);
        tick();
        ls_start(1'b0, 2'b10, 32'h500, 32'h0);
        rst = 1'b0;
        tick();
        chk("arst_tie_ls_first", mem_a, 32'h500);
        wait_done(1'b1, e);
        if_req = 1'b0; ls_req = 1'b0;
        chk("arst_ls_lat", e, 5);
        chk("arst_ls_rdata", ls_rdata, 32'hA4A3A2A1);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end

endmodule
